multicycle_run_ctrl: RTL and testbench

Synthesizable run-control block between the board/bench stimulus and the MultiCycle core. It sequences the core reset, gates the core clock-enable for free-run, single-step and halt, and stops the core on a configurable number of STATE breakpoints. It also counts executed core cycles and snapshots OUT on every halt. It replaces per-cycle `$stop` stepping in simulation with the same behaviour in hardware.

---
 rtl/multicycle_rc_pkg.sv | 18 +
 rtl/multicycle_run_ctrl_bp_match.sv | 21 ++
 rtl/multicycle_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_run_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_rc_pkg.sv
// Shared types and default parameter values for the MultiCycle run-control block.
package multicycle_rc_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALTED   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } rc_state_t;

    localparam int DEF_STATE_W  = 4;
    localparam int DEF_OUT_W    = 8;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_RST_HOLD = 4;
    localparam int DEF_NUM_BP   = 2;
    localparam int DEF_AUTORUN  = 0;

endpackage

// File: rtl/multicycle_run_ctrl_bp_match.sv
// NUM_BP parallel STATE comparators; bit i is set when breakpoint i is enabled and equals core_state.
module rc_bp_match
    import multicycle_rc_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int NUM_BP  = DEF_NUM_BP
) (
    input  logic [NUM_BP-1:0]         bp_en,
    input  logic [NUM_BP*STATE_W-1:0] bp_state,
    input  logic [STATE_W-1:0]        core_state,
    output logic [NUM_BP-1:0]         match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = bp_en[i] && (core_state == bp_state[i*STATE_W +: STATE_W]);
        end
    end

endmodule

// File: rtl/multicycle_run_ctrl.sv
// Run control for the MultiCycle core: reset sequencing, run/step/halt clock-enable gating,
// cycle counting and OUT snapshot. Breakpoints are built only when MULTICYCLE_RC_BP_EN is defined.
module multicycle_run_ctrl
    import multicycle_rc_pkg::*;
#(
    parameter int STATE_W  = DEF_STATE_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int NUM_BP   = DEF_NUM_BP,
    parameter int AUTORUN  = DEF_AUTORUN
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      run,
    input  logic                      step,
    input  logic                      halt,
    input  logic                      sreset,
    input  logic [NUM_BP-1:0]         bp_en,
    input  logic [NUM_BP*STATE_W-1:0] bp_state,
    input  logic [STATE_W-1:0]        core_state,
    input  logic [OUT_W-1:0]          core_out,
    output logic                      core_rst_n,
    output logic                      core_en,
    output logic                      halted,
    output logic [NUM_BP-1:0]         bp_hit,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [OUT_W-1:0]          out_snap
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    rc_state_t         state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              prev_run;
    logic [NUM_BP-1:0] match_vec;
    logic              bp_match;
    logic              hit_load;
    logic              hit_clear;
    logic              halt_entry;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef MULTICYCLE_RC_BP_EN
    logic [NUM_BP-1:0] bp_hit_q;

    rc_bp_match #(
        .STATE_W (STATE_W),
        .NUM_BP  (NUM_BP)
    ) u_bp_match (
        .bp_en      (bp_en),
        .bp_state   (bp_state),
        .core_state (core_state),
        .match      (match_vec)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bp_hit_q <= '0;
        end else if (sreset) begin
            bp_hit_q <= '0;
        end else if (hit_load) begin
            bp_hit_q <= match_vec;
        end else if (hit_clear) begin
            bp_hit_q <= '0;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;

    assign match_vec = '0;
    assign bp_hit    = '0;
    assign unused_bp = ^{bp_en, bp_state, core_state, hit_load, hit_clear};
`endif

    // The first RUN cycle ignores matches so a resume from a breakpoint state can advance.
    assign bp_match   = (state == ST_RUN) && prev_run && (|match_vec);
    assign halt_entry = (state_nxt == ST_HALTED) && (state != ST_HALTED);

    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        hit_load  = 1'b0;
        hit_clear = 1'b0;
        case (state)
            ST_RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = (AUTORUN != 0) ? ST_RUN : ST_HALTED;
                end
            end
            ST_HALTED: begin
                // A halt pulse outranks step/run here and simply leaves the core stopped.
                if (!halt) begin
                    if (step) begin
                        state_nxt = ST_STEP;
                        hit_clear = 1'b1;
                    end else if (run) begin
                        state_nxt = ST_RUN;
                        hit_clear = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                core_en   = !halt;
                state_nxt = ST_HALTED;
            end
            ST_RUN: begin
                core_en  = !halt && !bp_match;
                hit_load = bp_match;
                if (halt || bp_match) begin
                    state_nxt = ST_HALTED;
                end
            end
            default: state_nxt = ST_RST_HOLD;
        endcase
        if (sreset) begin
            state_nxt = ST_RST_HOLD;
            core_en   = 1'b0;
            hit_load  = 1'b0;
            hit_clear = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_RST_HOLD;
            hold_cnt   <= '0;
            prev_run   <= 1'b0;
            core_rst_n <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= (state == ST_RST_HOLD && state_nxt == ST_RST_HOLD && !sreset)
                          ? hold_cnt + HOLD_W'(1) : '0;
            prev_run   <= (state == ST_RUN);
            core_rst_n <= (state_nxt != ST_RST_HOLD);
            halted     <= (state_nxt == ST_HALTED);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_cnt <= '0;
            out_snap  <= '0;
        end else if (sreset) begin
            cycle_cnt <= '0;
            out_snap  <= '0;
        end else begin
            if (core_en) begin
                cycle_cnt <= sat_inc(cycle_cnt);
            end
            if (halt_entry) begin
                out_snap <= core_out;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_run_ctrl.sv
// Directed bench: a default instance, a CNT_W=4 twin sharing its stimulus, and an AUTORUN=1 instance.
module tb_multicycle_run_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic       run, step, halt, sreset, a_sreset;
    logic [1:0] bp_en;
    logic [7:0] bp_state;
    logic [3:0] core_state;
    logic [7:0] core_out;

    logic        core_rst_n, core_en, halted;
    logic [1:0]  bp_hit;
    logic [31:0] cycle_cnt;
    logic [7:0]  out_snap;

    logic        s_core_rst_n, s_core_en, s_halted;
    logic [1:0]  s_bp_hit;
    logic [3:0]  s_cycle_cnt;
    logic [7:0]  s_out_snap;

    logic        a_core_rst_n, a_core_en, a_halted;
    logic [1:0]  a_bp_hit;
    logic [31:0] a_cycle_cnt;
    logic [7:0]  a_out_snap;

    int total = 0;
    int bad = 0;
    int en_pulses = 0;

    multicycle_run_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .run(run), .step(step), .halt(halt), .sreset(sreset),
        .bp_en(bp_en), .bp_state(bp_state), .core_state(core_state), .core_out(core_out),
        .core_rst_n(core_rst_n), .core_en(core_en), .halted(halted), .bp_hit(bp_hit),
        .cycle_cnt(cycle_cnt), .out_snap(out_snap)
    );

    multicycle_run_ctrl #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET_N(RESET_N), .run(run), .step(step), .halt(halt), .sreset(sreset),
        .bp_en(bp_en), .bp_state(bp_state), .core_state(core_state), .core_out(core_out),
        .core_rst_n(s_core_rst_n), .core_en(s_core_en), .halted(s_halted), .bp_hit(s_bp_hit),
        .cycle_cnt(s_cycle_cnt), .out_snap(s_out_snap)
    );

    multicycle_run_ctrl #(.AUTORUN(1)) dut_auto (
        .CLK(CLK), .RESET_N(RESET_N), .run(1'b0), .step(1'b0), .halt(1'b0), .sreset(a_sreset),
        .bp_en(2'b00), .bp_state(bp_state), .core_state(core_state), .core_out(core_out),
        .core_rst_n(a_core_rst_n), .core_en(a_core_en), .halted(a_halted), .bp_hit(a_bp_hit),
        .cycle_cnt(a_cycle_cnt), .out_snap(a_out_snap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock cycle; the bench's core model advances STATE when the main instance enabled it.
    task automatic cyc();
        logic en_s;
        #1;
        en_s = core_en;
        @(posedge CLK);
        #1;
        if (en_s) begin
            en_pulses++;
            core_state = core_state + 4'd1;
        end
        if (!core_rst_n) core_state = 4'd0;
        core_out = {4'hA, core_state};
    endtask

    task automatic test_reset();
        #2;
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL rst_core_en: got %b want 0", core_en); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
        total++; if (out_snap !== 8'h00) begin bad++; $display("FAIL rst_out_snap: got %h want 00", out_snap); end
        total++; if (bp_hit !== 2'b00) begin bad++; $display("FAIL rst_bp_hit: got %b want 00", bp_hit); end
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (3) cyc();
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL hold_3rd_edge: got %b want 0", core_rst_n); end
        total++; if (a_core_en !== 1'b0) begin bad++; $display("FAIL auto_hold_en: got %b want 0", a_core_en); end
        cyc();
        total++; if (core_rst_n !== 1'b1) begin bad++; $display("FAIL hold_4th_edge: got %b want 1", core_rst_n); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_after_hold: got %b want 1", halted); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL cnt_after_hold: got %0d want 0", cycle_cnt); end
        total++; if (out_snap !== 8'hA0) begin bad++; $display("FAIL snap_after_hold: got %h want a0", out_snap); end
        total++; if (a_core_en !== 1'b1) begin bad++; $display("FAIL auto_run_after_hold: got %b want 1", a_core_en); end
        total++; if (a_halted !== 1'b0) begin bad++; $display("FAIL auto_halted: got %b want 0", a_halted); end
    endtask

    task automatic test_step();
        int p0;
        logic [7:0] exp_snap;
        p0 = en_pulses;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            total++; if (core_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL step_en[%0d]: got en=%b halted=%b want en=1 halted=0", k, core_en, halted); end
            exp_snap = 8'hA0 + 8'(k);
            cyc();
            total++; if (core_en !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL step_done[%0d]: got en=%b halted=%b want en=0 halted=1", k, core_en, halted); end
            total++; if (out_snap !== exp_snap) begin bad++; $display("FAIL step_snap[%0d]: got %h want %h", k, out_snap, exp_snap); end
            cyc();
        end
        total++; if (en_pulses - p0 !== 3) begin bad++; $display("FAIL step_pulses: got %0d want 3", en_pulses - p0); end
        total++; if (cycle_cnt !== 32'd3) begin bad++; $display("FAIL step_cnt: got %0d want 3", cycle_cnt); end
    endtask

    task automatic test_run_halt();
        run = 1'b1;
        cyc();
        run = 1'b0;
        total++; if (core_en !== 1'b1) begin bad++; $display("FAIL run_first_en: got %b want 1", core_en); end
        repeat (10) cyc();
        halt = 1'b1;
        #1;
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL halt_gate: got %b want 0", core_en); end
        cyc();
        halt = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL run_halted: got %b want 1", halted); end
        total++; if (cycle_cnt !== 32'd13) begin bad++; $display("FAIL run_cnt: got %0d want 13", cycle_cnt); end
        total++; if (out_snap !== 8'hAD) begin bad++; $display("FAIL run_snap: got %h want ad", out_snap); end
    endtask

    task automatic test_breakpoint();
        bp_state = {4'h9, 4'h5};
        bp_en    = 2'b01;
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (8) cyc();
`ifdef MULTICYCLE_RC_BP_EN
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL bp_gate: got %b want 0", core_en); end
        cyc();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_halted: got %b want 1", halted); end
        total++; if (bp_hit !== 2'b01) begin bad++; $display("FAIL bp_hit: got %b want 01", bp_hit); end
        total++; if (cycle_cnt !== 32'd21) begin bad++; $display("FAIL bp_cnt: got %0d want 21", cycle_cnt); end
        total++; if (out_snap !== 8'hA5) begin bad++; $display("FAIL bp_snap: got %h want a5", out_snap); end
        run = 1'b1;
        cyc();
        run = 1'b0;
        total++; if (core_en !== 1'b1) begin bad++; $display("FAIL bp_resume_skip: got %b want 1", core_en); end
        total++; if (bp_hit !== 2'b00) begin bad++; $display("FAIL bp_hit_clear: got %b want 00", bp_hit); end
        cyc();
`else
        total++; if (core_en !== 1'b1) begin bad++; $display("FAIL nobp_no_gate: got %b want 1", core_en); end
        cyc();
`endif
        halt = 1'b1;
        #1;
        total++; if (core_en !== 1'b0) begin bad++; $display("FAIL bp_halt_gate: got %b want 0", core_en); end
        cyc();
        halt = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_end_halted: got %b want 1", halted); end
        total++; if (cycle_cnt !== 32'd22) begin bad++; $display("FAIL bp_end_cnt: got %0d want 22", cycle_cnt); end
        total++; if (out_snap !== 8'hA6) begin bad++; $display("FAIL bp_end_snap: got %h want a6", out_snap); end
        total++; if (bp_hit !== 2'b00) begin bad++; $display("FAIL bp_end_hit: got %b want 00", bp_hit); end
        bp_en = 2'b00;
    endtask

    task automatic test_sreset();
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (2) cyc();
        sreset = 1'b1;
        cyc();
        sreset = 1'b0;
        total++; if (core_rst_n !== 1'b0 || core_en !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL sreset_ctrl: got rst_n=%b en=%b halted=%b want 0 0 0", core_rst_n, core_en, halted); end
        total++; if (cycle_cnt !== 32'd0 || out_snap !== 8'h00) begin bad++; $display("FAIL sreset_clear: got cnt=%0d snap=%h want 0 00", cycle_cnt, out_snap); end
        repeat (3) cyc();
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL sreset_hold: got %b want 0", core_rst_n); end
        cyc();
        total++; if (core_rst_n !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL sreset_release: got rst_n=%b halted=%b want 1 1", core_rst_n, halted); end
        total++; if (out_snap !== 8'hA0) begin bad++; $display("FAIL sreset_snap: got %h want a0", out_snap); end
    endtask

    task automatic test_saturation();
        run = 1'b1;
        cyc();
        run = 1'b0;
        repeat (20) cyc();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        total++; if (cycle_cnt !== 32'd20) begin bad++; $display("FAIL sat_wide_cnt: got %0d want 20", cycle_cnt); end
        total++; if (s_cycle_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt: got %h want f", s_cycle_cnt); end
        total++; if (s_halted !== 1'b1) begin bad++; $display("FAIL sat_halted: got %b want 1", s_halted); end
    endtask

    task automatic test_autorun_sreset();
        a_sreset = 1'b1;
        cyc();
        a_sreset = 1'b0;
        total++; if (a_core_rst_n !== 1'b0 || a_core_en !== 1'b0 || a_cycle_cnt !== 32'd0) begin bad++; $display("FAIL auto_sreset: got rst_n=%b en=%b cnt=%0d want 0 0 0", a_core_rst_n, a_core_en, a_cycle_cnt); end
        repeat (3) cyc();
        total++; if (a_core_rst_n !== 1'b0 || a_core_en !== 1'b0) begin bad++; $display("FAIL auto_hold: got rst_n=%b en=%b want 0 0", a_core_rst_n, a_core_en); end
        cyc();
        total++; if (a_core_rst_n !== 1'b1 || a_core_en !== 1'b1 || a_halted !== 1'b0) begin bad++; $display("FAIL auto_resume: got rst_n=%b en=%b halted=%b want 1 1 0", a_core_rst_n, a_core_en, a_halted); end
        cyc();
        total++; if (a_cycle_cnt !== 32'd1) begin bad++; $display("FAIL auto_cnt: got %0d want 1", a_cycle_cnt); end
    endtask

    task automatic test_async_reset_mid_run();
        run = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        RESET_N = 1'b0;
        #1;
        total++; if (core_en !== 1'b0 || core_rst_n !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL async_ctrl: got en=%b rst_n=%b halted=%b want 0 0 0", core_en, core_rst_n, halted); end
        total++; if (cycle_cnt !== 32'd0 || out_snap !== 8'h00) begin bad++; $display("FAIL async_data: got cnt=%0d snap=%h want 0 00", cycle_cnt, out_snap); end
    endtask

    initial begin
        RESET_N    = 1'b0;
        run        = 1'b0;
        step       = 1'b0;
        halt       = 1'b0;
        sreset     = 1'b0;
        a_sreset   = 1'b0;
        bp_en      = 2'b00;
        bp_state   = 8'h00;
        core_state = 4'd0;
        core_out   = 8'hA0;
        test_reset();
        test_step();
        test_run_halt();
        test_breakpoint();
        test_sreset();
        test_saturation();
        test_autorun_sreset();
        test_async_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
